// File: rtl/ddr3_port_arbiter_if.sv
// Bus bundle between one write master, two read masters and a DDR3 controller port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface ddr3_port_arbiter_if;
    logic [26:0]  wr_address;
    logic [255:0] wr_writedata;
    logic         wr_write;
    logic [4:0]   wr_burstcount;
    logic         wr_waitrequest;

    logic [26:0]  rd0_address;
    logic         rd0_read;
    logic [4:0]   rd0_burstcount;
    logic         rd0_waitrequest;
    logic [255:0] rd0_readdata;
    logic         rd0_readdatavalid;

    logic [26:0]  rd1_address;
    logic         rd1_read;
    logic [4:0]   rd1_burstcount;
    logic         rd1_waitrequest;
    logic [255:0] rd1_readdata;
    logic         rd1_readdatavalid;

    logic [26:0]  ddr3_address;
    logic         ddr3_read;
    logic         ddr3_write;
    logic [255:0] ddr3_writedata;
    logic [4:0]   ddr3_burstcount;
    logic         ddr3_waitrequest;
    logic [255:0] ddr3_readdata;
    logic         ddr3_readdatavalid;

    logic [3:0]   tag_level;
    logic         err_orphan;

    modport slave (
        input  wr_address, wr_writedata, wr_write, wr_burstcount,
        output wr_waitrequest,
        input  rd0_address, rd0_read, rd0_burstcount,
        output rd0_waitrequest, rd0_readdata, rd0_readdatavalid,
        input  rd1_address, rd1_read, rd1_burstcount,
        output rd1_waitrequest, rd1_readdata, rd1_readdatavalid,
        output ddr3_address, ddr3_read, ddr3_write, ddr3_writedata, ddr3_burstcount,
        input  ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
        output tag_level, err_orphan
    );

    modport master (
        output wr_address, wr_writedata, wr_write, wr_burstcount,
        input  wr_waitrequest,
        output rd0_address, rd0_read, rd0_burstcount,
        input  rd0_waitrequest, rd0_readdata, rd0_readdatavalid,
        output rd1_address, rd1_read, rd1_burstcount,
        input  rd1_waitrequest, rd1_readdata, rd1_readdatavalid,
        input  ddr3_address, ddr3_read, ddr3_write, ddr3_writedata, ddr3_burstcount,
        output ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
        input  tag_level, err_orphan
    );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller port between a write master and two
// read masters; a tag FIFO records read ownership so return beats route back correctly.
module ddr3_port_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int TAG_DEPTH = 8
) (
    input logic                ddr3clk,
    input logic                ddr3clk_reset,
    ddr3_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_ARB      = 2'd0;
    localparam logic [1:0] ST_RD_CMD   = 2'd1;
    localparam logic [1:0] ST_WR_BURST = 2'd2;

    localparam logic [1:0] SEL_WR  = 2'd0;
    localparam logic [1:0] SEL_RD0 = 2'd1;
    localparam logic [1:0] SEL_RD1 = 2'd2;

    localparam int         PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [3:0] DEPTH  = 4'(TAG_DEPTH);
    localparam logic [4:0] BC_MAX = 5'(MAX_BURST);

    logic [1:0]       state, sel, last;
    logic [4:0]       beat_cnt, ret_cnt, wr_bc_q;
    logic [26:0]      wr_addr_q;
    logic [5:0]       tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]       level;
    logic             err_q;

    logic       req_wr, req_rd0, req_rd1, gnt_any;
    logic [1:0] gnt;
    logic       first_beat, wr_accept, wr_last, rd_accept, has_tag, ret_beat, ret_last;
    logic [4:0] wr_len, cur_bc;
    logic [5:0] head;

    function automatic logic [4:0] clamp_bc(input logic [4:0] bc);
        return (bc > BC_MAX) ? BC_MAX : bc;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full check uses the registered level only, so a same-cycle pop never frees a slot early.
    assign req_wr  = bus.wr_write;
    assign req_rd0 = bus.rd0_read && (level < DEPTH);
    assign req_rd1 = bus.rd1_read && (level < DEPTH);

    always_comb begin
        gnt_any = 1'b1;
        gnt     = SEL_WR;
        case (last)
            SEL_WR: begin
                if (req_rd0)      gnt = SEL_RD0;
                else if (req_rd1) gnt = SEL_RD1;
                else if (req_wr)  gnt = SEL_WR;
                else              gnt_any = 1'b0;
            end
            SEL_RD0: begin
                if (req_rd1)      gnt = SEL_RD1;
                else if (req_wr)  gnt = SEL_WR;
                else if (req_rd0) gnt = SEL_RD0;
                else              gnt_any = 1'b0;
            end
            default: begin
                if (req_wr)       gnt = SEL_WR;
                else if (req_rd0) gnt = SEL_RD0;
                else if (req_rd1) gnt = SEL_RD1;
                else              gnt_any = 1'b0;
            end
        endcase
    end

    assign first_beat = (beat_cnt == '0);
    assign wr_len     = clamp_bc(first_beat ? bus.wr_burstcount : wr_bc_q);
    assign wr_accept  = (state == ST_WR_BURST) && bus.wr_write && !bus.ddr3_waitrequest;
    assign wr_last    = wr_accept && (beat_cnt + 5'd1 == wr_len);

    assign cur_bc    = (sel == SEL_RD1) ? bus.rd1_burstcount : bus.rd0_burstcount;
    assign rd_accept = (state == ST_RD_CMD) && !bus.ddr3_waitrequest;

    assign head     = tag_mem[rd_ptr];
    assign has_tag  = (level != '0);
    assign ret_beat = bus.ddr3_readdatavalid && has_tag;
    assign ret_last = ret_beat && (ret_cnt + 5'd1 == head[4:0]);

    assign bus.rd0_readdata      = bus.ddr3_readdata;
    assign bus.rd1_readdata      = bus.ddr3_readdata;
    assign bus.rd0_readdatavalid = ret_beat && !head[5];
    assign bus.rd1_readdatavalid = ret_beat && head[5];
    assign bus.ddr3_writedata    = bus.wr_writedata;
    assign bus.tag_level         = level;
    assign bus.err_orphan        = err_q;

    always_comb begin
        bus.ddr3_read       = 1'b0;
        bus.ddr3_write      = 1'b0;
        bus.ddr3_address    = '0;
        bus.ddr3_burstcount = '0;
        bus.wr_waitrequest  = 1'b1;
        bus.rd0_waitrequest = 1'b1;
        bus.rd1_waitrequest = 1'b1;
        case (state)
            ST_RD_CMD: begin
                bus.ddr3_read       = 1'b1;
                bus.ddr3_address    = (sel == SEL_RD1) ? bus.rd1_address : bus.rd0_address;
                bus.ddr3_burstcount = cur_bc;
                if (sel == SEL_RD1) bus.rd1_waitrequest = bus.ddr3_waitrequest;
                else                bus.rd0_waitrequest = bus.ddr3_waitrequest;
            end
            ST_WR_BURST: begin
                bus.ddr3_write      = bus.wr_write;
                bus.ddr3_address    = first_beat ? bus.wr_address : wr_addr_q;
                bus.ddr3_burstcount = first_beat ? bus.wr_burstcount : wr_bc_q;
                bus.wr_waitrequest  = bus.ddr3_waitrequest;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ddr3clk) begin
        if (ddr3clk_reset) begin
            state     <= ST_ARB;
            sel       <= SEL_WR;
            last      <= SEL_RD1;
            beat_cnt  <= '0;
            wr_addr_q <= '0;
            wr_bc_q   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ret_cnt   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (gnt_any) begin
                        sel   <= gnt;
                        last  <= gnt;
                        state <= (gnt == SEL_WR) ? ST_WR_BURST : ST_RD_CMD;
                    end
                end
                ST_RD_CMD: begin
                    if (rd_accept) state <= ST_ARB;
                end
                ST_WR_BURST: begin
                    if (wr_accept) begin
                        if (first_beat) begin
                            wr_addr_q <= bus.wr_address;
                            wr_bc_q   <= bus.wr_burstcount;
                        end
                        if (wr_last) begin
                            beat_cnt <= '0;
                            state    <= ST_ARB;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                default: state <= ST_ARB;
            endcase

            if (rd_accept) wr_ptr <= ptr_inc(wr_ptr);
            if (ret_last)  rd_ptr <= ptr_inc(rd_ptr);
            if (rd_accept && !ret_last)      level <= level + 4'd1;
            else if (ret_last && !rd_accept) level <= level - 4'd1;

            if (ret_beat) ret_cnt <= ret_last ? '0 : ret_cnt + 5'd1;
            if (bus.ddr3_readdatavalid && !has_tag) err_q <= 1'b1;
        end
    end

    always_ff @(posedge ddr3clk) begin
        if (rd_accept && !ddr3clk_reset)
            tag_mem[wr_ptr] <= {sel == SEL_RD1, clamp_bc(cur_bc)};
    end
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter: expected controller commands and routed return
// beats are queued as stimulus is driven and compared as the DUT produces them.
module tb_ddr3_port_arbiter;
    logic ddr3clk = 1'b0;
    logic ddr3clk_reset = 1'b1;
    always #5 ddr3clk = ~ddr3clk;

    ddr3_port_arbiter_if bus ();

    ddr3_port_arbiter #(.MAX_BURST(16), .TAG_DEPTH(8)) dut (
        .ddr3clk       (ddr3clk),
        .ddr3clk_reset (ddr3clk_reset),
        .bus           (bus.slave)
    );

    typedef struct packed {
        logic         is_wr;
        logic [26:0]  addr;
        logic [4:0]   bc;
        logic [255:0] data;
    } cmd_t;

    typedef struct packed {
        logic         owner;
        logic [255:0] data;
    } beat_t;

    cmd_t         cmd_q[$];
    beat_t        drive_q[$];
    logic [255:0] ret0_q[$];
    logic [255:0] ret1_q[$];

    int checks = 0;
    int errors = 0;
    int peak = 0;
    int wr_seen = 0;

    int          wr_left, wr_len, wr_beat, pause, rd0_left, rd1_left, rd0_bc, rd1_bc;
    int          rd0_issued, rd1_issued, ret_budget, wr_seen_at_rd;
    logic        pause_en, stall_en;
    logic [26:0] wr_addr, rd0_addr, rd1_addr;

    task automatic check_eq(input string tag, input logic [299:0] got, input logic [299:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] wdata(input logic [26:0] a, input int b);
        return {16'hABCD, 205'd0, a, 8'(b)};
    endfunction

    function automatic logic [255:0] rdata(input logic [26:0] a, input int b);
        return {16'h5EAD, 205'd0, a, 8'(b)};
    endfunction

    task automatic exp_wr(input logic [26:0] a, input int len, input int nbeats);
        for (int i = 0; i < nbeats; i++) cmd_q.push_back({1'b1, a, 5'(len), wdata(a, i)});
    endtask

    task automatic exp_rd(input logic [26:0] a, input int bc);
        cmd_q.push_back({1'b0, a, 5'(bc), 256'd0});
    endtask

    always @(negedge ddr3clk) begin : monitor
        cmd_t c;
        if (!ddr3clk_reset) begin
            if (int'(bus.tag_level) > peak) peak = int'(bus.tag_level);
            if (bus.ddr3_read && bus.ddr3_write) check_eq("rd_wr_overlap", 1, 0);
            if (bus.ddr3_read && !bus.ddr3_waitrequest) begin
                c = {1'b0, bus.ddr3_address, bus.ddr3_burstcount, 256'd0};
                if (cmd_q.size() == 0) check_eq("rd_cmd_unexpected", c, 0);
                else check_eq("rd_cmd", c, cmd_q.pop_front());
            end
            if (bus.ddr3_write && !bus.ddr3_waitrequest) begin
                wr_seen++;
                c = {1'b1, bus.ddr3_address, bus.ddr3_burstcount, bus.ddr3_writedata};
                if (cmd_q.size() == 0) check_eq("wr_beat_unexpected", c, 0);
                else check_eq("wr_beat", c, cmd_q.pop_front());
            end
            if (bus.rd0_readdatavalid) begin
                if (ret0_q.size() == 0) check_eq("rd0_ret_unexpected", 1, 0);
                else check_eq("rd0_ret", bus.rd0_readdata, ret0_q.pop_front());
            end
            if (bus.rd1_readdatavalid) begin
                if (ret1_q.size() == 0) check_eq("rd1_ret_unexpected", 1, 0);
                else check_eq("rd1_ret", bus.rd1_readdata, ret1_q.pop_front());
            end
        end
    end

    task automatic drive_inputs();
        beat_t b;
        bus.wr_write       = (wr_left > 0) && (pause == 0);
        bus.wr_writedata   = wdata(wr_addr, wr_beat);
        bus.rd0_read       = rd0_left > 0;
        bus.rd0_address    = rd0_addr;
        bus.rd0_burstcount = 5'(rd0_bc);
        bus.rd1_read       = rd1_left > 0;
        bus.rd1_address    = rd1_addr;
        bus.rd1_burstcount = 5'(rd1_bc);
        bus.ddr3_waitrequest = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (ret_budget > 0 && drive_q.size() > 0) begin
            b = drive_q.pop_front();
            bus.ddr3_readdatavalid = 1'b1;
            bus.ddr3_readdata      = b.data;
            if (b.owner) ret1_q.push_back(b.data);
            else         ret0_q.push_back(b.data);
            ret_budget--;
        end else begin
            bus.ddr3_readdatavalid = 1'b0;
            bus.ddr3_readdata      = '0;
        end
    endtask

    task automatic step();
        logic a0, a1, aw;
        @(negedge ddr3clk);
        a0 = bus.rd0_read && !bus.rd0_waitrequest;
        a1 = bus.rd1_read && !bus.rd1_waitrequest;
        aw = bus.wr_write && !bus.wr_waitrequest;
        @(posedge ddr3clk);
        #1;
        if (pause > 0) pause--;
        if (a0) begin
            for (int i = 0; i < int'(bus.rd0_burstcount); i++)
                drive_q.push_back({1'b0, rdata(bus.rd0_address, i)});
            rd0_left--;
            rd0_issued++;
            rd0_addr += 27'h10;
            wr_seen_at_rd = wr_seen;
        end
        if (a1) begin
            for (int i = 0; i < int'(bus.rd1_burstcount); i++)
                drive_q.push_back({1'b1, rdata(bus.rd1_address, i)});
            rd1_left--;
            rd1_issued++;
            rd1_addr += 27'h10;
        end
        if (aw) begin
            wr_beat++;
            if (wr_beat == wr_len) begin
                wr_beat = 0;
                wr_left--;
                wr_addr += 27'h40;
                bus.wr_address    = wr_addr;
                bus.wr_burstcount = 5'(wr_len);
            end else begin
                // Later beats must not depend on the master holding address/burstcount.
                bus.wr_address    = '1;
                bus.wr_burstcount = 5'd1;
                if (pause_en && wr_beat == 4) begin
                    pause    = 3;
                    pause_en = 1'b0;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        ddr3clk_reset = 1'b1;
        wr_left = 0; wr_len = 1; wr_beat = 0; pause = 0; pause_en = 1'b0; stall_en = 1'b0;
        rd0_left = 0; rd1_left = 0; rd0_bc = 1; rd1_bc = 1; rd0_issued = 0; rd1_issued = 0;
        ret_budget = 0; wr_seen_at_rd = -1;
        wr_addr = '0; rd0_addr = '0; rd1_addr = '0;
        cmd_q.delete(); drive_q.delete(); ret0_q.delete(); ret1_q.delete();
        bus.wr_address = '0; bus.wr_burstcount = 5'd1;
        drive_inputs();
        repeat (2) @(posedge ddr3clk);
        #1;
        ddr3clk_reset = 1'b0;
        peak = 0;
        wr_seen = 0;
    endtask

    task automatic start_write(input logic [26:0] a, input int len, input int bursts);
        wr_addr = a; wr_len = len; wr_left = bursts; wr_beat = 0;
        bus.wr_address = a; bus.wr_burstcount = 5'(len);
        drive_inputs();
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 300 && (drive_q.size() > 0 || ret0_q.size() > 0 || ret1_q.size() > 0); n++)
            step();
        check_eq(tag, drive_q.size() + ret0_q.size() + ret1_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_ddr3_read", bus.ddr3_read, 0);
        check_eq("rst_ddr3_write", bus.ddr3_write, 0);
        check_eq("rst_wr_wait", bus.wr_waitrequest, 1);
        check_eq("rst_rd0_wait", bus.rd0_waitrequest, 1);
        check_eq("rst_rd1_wait", bus.rd1_waitrequest, 1);
        check_eq("rst_rdvalid", {bus.rd0_readdatavalid, bus.rd1_readdatavalid}, 0);
        check_eq("rst_tag_level", bus.tag_level, 0);
        check_eq("rst_err_orphan", bus.err_orphan, 0);

        // Two readers together: rd0 first, returns routed in issue order
        do_reset();
        stall_en = 1'b1;
        rd0_addr = 27'h100; rd0_bc = 4; rd0_left = 1;
        rd1_addr = 27'h200; rd1_bc = 4; rd1_left = 1;
        exp_rd(27'h100, 4);
        exp_rd(27'h200, 4);
        drive_inputs();
        for (int n = 0; n < 60 && rd0_issued + rd1_issued < 2; n++) step();
        check_eq("t1_issued", rd0_issued + rd1_issued, 2);
        check_eq("t1_level_2", bus.tag_level, 2);
        ret_budget = 1000;
        drain("t1_drain");
        check_eq("t1_peak", peak, 2);
        check_eq("t1_level_0", bus.tag_level, 0);
        check_eq("t1_cmd_q", cmd_q.size(), 0);

        // Paused write burst blocks a pending read until its last beat
        do_reset();
        exp_wr(27'h3000, 8, 8);
        exp_rd(27'h180, 2);
        pause_en = 1'b1;
        rd0_addr = 27'h180; rd0_bc = 2; rd0_left = 1;
        ret_budget = 1000;
        start_write(27'h3000, 8, 1);
        for (int n = 0; n < 60 && rd0_issued < 1; n++) step();
        check_eq("t2_rd_issued", rd0_issued, 1);
        check_eq("t2_wr_beats", wr_seen, 8);
        check_eq("t2_rd_after_wr", wr_seen_at_rd, 8);
        drain("t2_drain");
        check_eq("t2_cmd_q", cmd_q.size(), 0);

        // Tag FIFO full: ninth burst held until first burst fully returns
        do_reset();
        rd0_addr = 27'h500; rd0_bc = 2; rd0_left = 9;
        for (int i = 0; i < 9; i++) exp_rd(27'h500 + 27'(i * 16), 2);
        drive_inputs();
        for (int n = 0; n < 100 && rd0_issued < 8; n++) step();
        repeat (5) step();
        check_eq("t3_full_issued", rd0_issued, 8);
        check_eq("t3_full_level", bus.tag_level, 8);
        check_eq("t3_full_wait", bus.rd0_waitrequest, 1);
        ret_budget = 1;
        repeat (3) step();
        check_eq("t3_half_issued", rd0_issued, 8);
        check_eq("t3_half_level", bus.tag_level, 8);
        ret_budget = 1;
        for (int n = 0; n < 10 && rd0_issued < 9; n++) step();
        check_eq("t3_ninth_issued", rd0_issued, 9);
        ret_budget = 1000;
        drain("t3_drain");
        check_eq("t3_level_0", bus.tag_level, 0);
        check_eq("t3_cmd_q", cmd_q.size(), 0);

        // All three requesting: grants rotate wr, rd0, rd1
        do_reset();
        stall_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_wr(27'h4000 + 27'(k * 64), 2, 2);
            exp_rd(27'h600 + 27'(k * 16), 1);
            exp_rd(27'h700 + 27'(k * 16), 1);
        end
        rd0_addr = 27'h600; rd0_bc = 1; rd0_left = 3;
        rd1_addr = 27'h700; rd1_bc = 1; rd1_left = 3;
        ret_budget = 1000;
        start_write(27'h4000, 2, 3);
        for (int n = 0; n < 300 && (wr_left + rd0_left + rd1_left) > 0; n++) step();
        check_eq("t4_all_issued", wr_left + rd0_left + rd1_left, 0);
        drain("t4_drain");
        check_eq("t4_cmd_q", cmd_q.size(), 0);

        // Orphan return beat
        do_reset();
        bus.ddr3_readdatavalid = 1'b1;
        bus.ddr3_readdata = rdata(27'h77, 0);
        #1;
        check_eq("t5_no_route", {bus.rd0_readdatavalid, bus.rd1_readdatavalid}, 0);
        @(posedge ddr3clk);
        #1;
        bus.ddr3_readdatavalid = 1'b0;
        check_eq("t5_orphan_set", bus.err_orphan, 1);
        repeat (5) step();
        check_eq("t5_orphan_held", bus.err_orphan, 1);
        do_reset();
        check_eq("t5_orphan_cleared", bus.err_orphan, 0);

        // Reset during beat 3 of 8, then a stale return beat after reset
        exp_wr(27'h5000, 8, 2);
        start_write(27'h5000, 8, 1);
        for (int n = 0; n < 20 && wr_beat < 2; n++) step();
        check_eq("t6_two_beats", wr_seen, 2);
        ddr3clk_reset = 1'b1;
        @(posedge ddr3clk);
        #1;
        check_eq("t6_write_low", bus.ddr3_write, 0);
        check_eq("t6_wr_wait", bus.wr_waitrequest, 1);
        check_eq("t6_read_low", bus.ddr3_read, 0);
        wr_left = 0;
        drive_inputs();
        ddr3clk_reset = 1'b0;
        check_eq("t6_cmd_q", cmd_q.size(), 0);
        bus.ddr3_readdatavalid = 1'b1;
        @(posedge ddr3clk);
        #1;
        bus.ddr3_readdatavalid = 1'b0;
        check_eq("t6_orphan_after_rst", bus.err_orphan, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr3_port_arbiter.md
DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter MAX_BURST, default 16, the largest legal burstcount on any port.
REQ-002 The block SHALL have parameter TAG_DEPTH, default 8, the maximum number of outstanding read bursts.

Ports:
REQ-003 The block SHALL have these ports, one clock and one synchronous active-high reset:
- ddr3clk  in  1  sole clock
- ddr3clk_reset  in  1  synchronous, active-high reset
- wr_address  in  27  write master burst address
- wr_writedata  in  256  write beat data
- wr_write  in  1  write request / beat valid
- wr_burstcount  in  5  beats in the write burst
- wr_waitrequest  out  1  stall to the write master
- rdN_address (N=0,1)  in  27  read master N address
- rdN_read  in  1  read request
- rdN_burstcount  in  5  beats requested
- rdN_waitrequest  out  1  stall to read master N
- rdN_readdata  out  256  return data
- rdN_readdatavalid  out  1  return beat valid
- ddr3_address  out  27  controller address
- ddr3_read / ddr3_write  out  1 each  controller commands
- ddr3_writedata  out  256  controller write data
- ddr3_burstcount  out  5  controller burstcount
- ddr3_waitrequest  in  1  controller stall
- ddr3_readdata  in  256  controller return data
- ddr3_readdatavalid  in  1  controller return valid
- tag_level  out  4  outstanding read bursts
- err_orphan  out  1  sticky: return beat arrived with no outstanding tag

Function
REQ-004 States SHALL be ST_ARB, ST_RD_CMD and ST_WR_BURST.
REQ-005 In ST_ARB, ddr3_read and ddr3_write SHALL be 0 and every waitrequest SHALL be 1.
REQ-006 ST_ARB SHALL register a grant to the highest-priority requester whose request is asserted: wr_write, or rdN_read when tag_level < TAG_DEPTH.
REQ-007 ST_ARB SHALL then move to ST_WR_BURST or ST_RD_CMD, giving one cycle of arbitration latency.
REQ-008 Priority SHALL be round-robin: the last granted requester becomes lowest; the order after reset is wr > rd0 > rd1.
REQ-009 In ST_RD_CMD, the granted master's address and burstcount SHALL drive ddr3_address and ddr3_burstcount combinationally, with ddr3_read = 1.
REQ-010 In ST_RD_CMD, the granted master's waitrequest SHALL equal ddr3_waitrequest; the other masters' waitrequest SHALL be 1.
REQ-011 On a ST_RD_CMD cycle with ddr3_waitrequest = 0, the block SHALL push {owner, burstcount} into the tag FIFO and return to ST_ARB.
REQ-012 In ST_WR_BURST, ddr3_write SHALL equal wr_write, ddr3_writedata SHALL equal wr_writedata and wr_waitrequest SHALL equal ddr3_waitrequest.
REQ-013 In ST_WR_BURST, address and burstcount SHALL be taken from wr_* on the first beat and held registered on later beats.
REQ-014 An accepted write beat is one with wr_write = 1 and ddr3_waitrequest = 0; each accepted beat SHALL increment the beat counter.
REQ-015 After the accepted beat numbered burstcount, the block SHALL return to ST_ARB; wr_write low mid-burst SHALL simply pause the burst.
REQ-016 rdN_readdata SHALL equal ddr3_readdata for both N, broadcast to both read masters.
REQ-017 rdN_readdatavalid SHALL equal ddr3_readdatavalid gated by (tag FIFO head owner == N), combinationally with zero latency.
REQ-018 Each return beat SHALL increment a return counter; on the beat numbered head burstcount, the block SHALL pop the tag and clear the counter.
REQ-019 A push and a pop in the same cycle SHALL both take effect, leaving tag_level unchanged.
REQ-020 The full check SHALL use the registered tag_level, with no bypass, so a full FIFO with a same-cycle pop still blocks new reads that cycle.
REQ-021 A ddr3_readdatavalid beat with the tag FIFO empty SHALL be dropped: no rdN_readdatavalid asserted, and err_orphan set to 1 until reset.
REQ-022 Writes SHALL be grantable while reads are outstanding; return routing SHALL be independent of command state.
REQ-023 Burstcount values SHALL be 1..MAX_BURST; 0 is illegal and its behaviour is undefined.

Reset
REQ-024 Reset SHALL give: state ST_ARB, ddr3_read = 0, ddr3_write = 0, all waitrequest = 1, rdN_readdatavalid = 0, tag FIFO empty, tag_level = 0, counters 0, err_orphan = 0, priority pointer at wr.
REQ-025 Reset asserted mid-burst or mid-return SHALL abort immediately; return beats arriving after reset SHALL set err_orphan.

Verification
REQ-026 Test: rd0 and rd1 request together after reset, each burst 4 -> rd0 granted first, then rd1; 8 returns route 4 to rd0 and then 4 to rd1; tag_level peaks at 2 and returns to 0.
REQ-027 Test: wr_write burst 8 with wr_write low for 3 cycles at beat 5 -> exactly 8 ddr3_write beats at a constant address; reads stay blocked until beat 8 is accepted.
REQ-028 Test: TAG_DEPTH = 8, returns withheld, rd0 issues 9 bursts -> 9th held with rd0_waitrequest = 1 until the first burst's last beat pops.
REQ-029 Test: all three request continuously -> grants rotate wr, rd0, rd1, wr, ... with no starvation.
REQ-030 Test: ddr3_readdatavalid pulse with no reads outstanding -> no rdN_readdatavalid, err_orphan = 1 and held until ddr3clk_reset.
REQ-031 Test: reset during write beat 3 of 8 -> next cycle ddr3_write = 0, wr_waitrequest = 1, state ST_ARB.
